// File: rtl/rx_crc_chk.sv
// Serial CRC accumulator with a trailing CRC-field compare (IDLE/ACCUM/CHECK/DONE).
// Optional macro CRC_SEED_PORT_EN adds a crc_seed input used as the clear value.
module rx_crc_chk #(
   parameter int                CRC_W = 13,
   parameter logic [CRC_W-1:0]  POLY  = 13'h19E7,
   parameter logic [CRC_W-1:0]  INIT  = '0
) (
   input  logic             clk,
   input  logic             g_rst_n,
`ifdef CRC_SEED_PORT_EN
   input  logic [CRC_W-1:0] crc_seed,
`endif
   input  logic             data,
   input  logic             crc_enable,
   input  logic             de_stuff,
   input  logic             initialize,
   input  logic             tx_success,
   input  logic             rx_success,
   input  logic             check_start,
   output logic [CRC_W-1:0] crc_val,
   output logic             chk_busy,
   output logic             chk_done,
   output logic             crc_err
);

   typedef enum logic [1:0] {IDLE, ACCUM, CHECK, DONE} state_t;

   localparam logic [CRC_W-1:0] CNT_LAST = CRC_W'(CRC_W - 1);
   localparam logic [CRC_W-1:0] CNT_ONE  = CRC_W'(1);

`ifdef CRC_SEED_PORT_EN
   localparam logic [CRC_W-1:0] RST_VAL = '0;
   logic [CRC_W-1:0] seed;
   assign seed = crc_seed;
`else
   localparam logic [CRC_W-1:0] RST_VAL = INIT;
   logic [CRC_W-1:0] seed;
   assign seed = INIT;
`endif

   state_t           state_reg, state_next;
   logic [CRC_W-1:0] crc_reg, crc_next;
   logic [CRC_W-1:0] cnt_reg, cnt_next;
   logic             mis_reg, mis_next;
   logic             err_reg, err_next;
   logic             done_reg, done_next;

   logic             accepted;
   logic             clear;
   logic             fb;
   logic [CRC_W-1:0] crc_step;
   logic [CRC_W-1:0] cmp_word;
   logic             exp_bit;
   logic             mis_bit;

   assign accepted = crc_enable & ~de_stuff;
   assign clear    = tx_success | rx_success | initialize;
   assign fb       = data ^ crc_reg[CRC_W-1];
   assign crc_step = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   // Shifting by the bit count brings the next CRC bit (MSB first) to the top.
   assign cmp_word = crc_reg << cnt_reg;
   assign exp_bit  = cmp_word[CRC_W-1];

   always_ff @(posedge clk or negedge g_rst_n) begin
      if (!g_rst_n) begin
         state_reg <= IDLE;
         crc_reg   <= RST_VAL;
         cnt_reg   <= '0;
         mis_reg   <= 1'b0;
         err_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         crc_reg   <= crc_next;
         cnt_reg   <= cnt_next;
         mis_reg   <= mis_next;
         err_reg   <= err_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      crc_next   = crc_reg;
      cnt_next   = cnt_reg;
      mis_next   = mis_reg;
      err_next   = err_reg;
      done_next  = 1'b0;
      mis_bit    = mis_reg | (data != exp_bit);

      if (clear) begin
         state_next = IDLE;
         crc_next   = seed;
         cnt_next   = '0;
         mis_next   = 1'b0;
         err_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (check_start) begin
                  // Empty frame: compare against the seed itself.
                  state_next = CHECK;
                  crc_next   = seed;
                  cnt_next   = '0;
                  mis_next   = 1'b0;
               end else if (accepted) begin
                  state_next = ACCUM;
                  crc_next   = crc_step;
               end
            end
            ACCUM: begin
               if (check_start) begin
                  state_next = CHECK;
                  cnt_next   = '0;
                  mis_next   = 1'b0;
               end else if (accepted) begin
                  crc_next = crc_step;
               end
            end
            CHECK: begin
               if (accepted) begin
                  mis_next = mis_bit;
                  cnt_next = cnt_reg + CNT_ONE;
                  if (cnt_reg == CNT_LAST) begin
                     state_next = DONE;
                     done_next  = 1'b1;
                     err_next   = mis_bit;
                  end
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign crc_val  = crc_reg;
   assign chk_busy = (state_reg == CHECK);
   assign chk_done = done_reg;
   assign crc_err  = err_reg;

endmodule

// File: tb/tb_rx_crc_chk.sv
// Self-checking bench for rx_crc_chk: vector table for accumulation, scoreboard
// queue for expected results, hand-written sequences for check/abort/reset cases.
module tb_rx_crc_chk;
   logic clk = 1'b0;
   logic g_rst_n = 1'b0;
   logic data = 1'b0, crc_enable = 1'b0, de_stuff = 1'b0;
   logic initialize = 1'b0, tx_success = 1'b0, rx_success = 1'b0, check_start = 1'b0;

   logic [12:0] crc13;
   logic        busy13, done13, err13;
   logic [31:0] crc32;
   logic        busy32, done32, err32;

`ifdef CRC_SEED_PORT_EN
   logic [12:0] seed13 = 13'h0;
   logic [31:0] seed32 = 32'hFFFFFFFF;
   localparam logic [31:0] RST32 = 32'h0;
`else
   localparam logic [31:0] RST32 = 32'hFFFFFFFF;
`endif

   always #5 clk = ~clk;

   rx_crc_chk dut13 (
      .clk(clk),
`ifdef CRC_SEED_PORT_EN
      .crc_seed(seed13),
`endif
      .g_rst_n(g_rst_n), .data(data), .crc_enable(crc_enable), .de_stuff(de_stuff),
      .initialize(initialize), .tx_success(tx_success), .rx_success(rx_success),
      .check_start(check_start), .crc_val(crc13), .chk_busy(busy13),
      .chk_done(done13), .crc_err(err13)
   );

   rx_crc_chk #(.CRC_W(32), .POLY(32'h1EDC6F41), .INIT(32'hFFFFFFFF)) dut32 (
      .clk(clk),
`ifdef CRC_SEED_PORT_EN
      .crc_seed(seed32),
`endif
      .g_rst_n(g_rst_n), .data(data), .crc_enable(crc_enable), .de_stuff(de_stuff),
      .initialize(initialize), .tx_success(tx_success), .rx_success(rx_success),
      .check_start(check_start), .crc_val(crc32), .chk_busy(busy32),
      .chk_done(done32), .crc_err(err32)
   );

   // Observed DUT selected by use32.
   bit          use32 = 1'b0;
   logic [31:0] obs_crc;
   logic        obs_busy, obs_done, obs_err;
   assign obs_crc  = use32 ? crc32 : {19'b0, crc13};
   assign obs_busy = use32 ? busy32 : busy13;
   assign obs_done = use32 ? done32 : done13;
   assign obs_err  = use32 ? err32 : err13;

   typedef struct { string name; logic [31:0] value; } exp_t;
   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;

   task automatic expect_val(input string name, input logic [31:0] v);
      exp_t e;
      e.name  = name;
      e.value = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] actual);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0h with no expectation queued", actual);
      end else begin
         e = sb_q.pop_front();
         if (actual !== e.value) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", e.name, actual, e.value);
         end else begin
            $display("ok   %s = %0h", e.name, actual);
         end
      end
   endtask

   task automatic drive(input logic d, input logic en, input logic st, input logic ini,
                        input logic txs, input logic rxs, input logic cs);
      @(negedge clk);
      data = d; crc_enable = en; de_stuff = st; initialize = ini;
      tx_success = txs; rx_success = rxs; check_start = cs;
      @(posedge clk);
      #1;
   endtask

   task automatic bit_in(input logic d);
      drive(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic init_pulse();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic start_pulse();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // check_start then the w-bit compare field MSB first; optionally an accepted
   // (wrong) bit alongside check_start and a stuffed (wrong) bit before bit stuff_at.
   task automatic run_check(input string tag, input logic [31:0] val, input int w,
                            input bit bit_on_start, input int stuff_at,
                            input logic exp_err, input logic [31:0] exp_crc);
      int busy_n;
      int done_n;
      busy_n = 0;
      done_n = 0;
      expect_val({tag, "_busy_cycles"}, 32'(w + ((stuff_at >= 0) ? 1 : 0)));
      expect_val({tag, "_done_pulses"}, 32'd1);
      expect_val({tag, "_crc_err"}, 32'(exp_err));
      expect_val({tag, "_crc_frozen"}, exp_crc);
      drive(bit_on_start ? ~val[w-1] : 1'b0, bit_on_start ? 1'b1 : 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      busy_n += int'(obs_busy); done_n += int'(obs_done);
      for (int i = w - 1; i >= 0; i--) begin
         if (stuff_at == i) begin
            drive(~val[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            busy_n += int'(obs_busy); done_n += int'(obs_done);
         end
         bit_in(val[i]);
         busy_n += int'(obs_busy); done_n += int'(obs_done);
      end
      for (int k = 0; k < 3; k++) begin
         idle();
         busy_n += int'(obs_busy); done_n += int'(obs_done);
      end
      sb_check(32'(busy_n));
      sb_check(32'(done_n));
      sb_check(32'(obs_err));
      sb_check(obs_crc);
   endtask

   typedef struct { logic clr; logic d; logic en; logic st; logic [12:0] exp; } vec_t;
   vec_t vecs[7];

   initial begin
      int done_n;
      int busy_n;
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 13'h19E7};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 13'h0A29};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 13'h0A29};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'h0A29};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 13'h0000};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'h0000};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 13'h19E7};

      repeat (3) @(posedge clk);
      #1;
      expect_val("rst_crc13", 32'h0);        sb_check({19'b0, crc13});
      expect_val("rst_crc32", RST32);        sb_check(crc32);
      expect_val("rst_busy", 32'h0);         sb_check(32'(busy13));
      expect_val("rst_done", 32'h0);         sb_check(32'(done13));
      expect_val("rst_err", 32'h0);          sb_check(32'(err13));
      @(negedge clk);
      g_rst_n = 1'b1;
      init_pulse();

      foreach (vecs[i]) begin
         if (vecs[i].clr) init_pulse();
         expect_val($sformatf("vec%0d_crc", i), {19'b0, vecs[i].exp});
         drive(vecs[i].d, vecs[i].en, vecs[i].st, 1'b0, 1'b0, 1'b0, 1'b0);
         sb_check({19'b0, crc13});
      end

      // Matching compare field.
      init_pulse(); bit_in(1'b1);
      run_check("good", 32'h19E7, 13, 1'b0, -1, 1'b0, 32'h19E7);

      // Bit 5 flipped; result held in DONE regardless of bits and check_start.
      init_pulse(); bit_in(1'b1);
      run_check("flip5", 32'h19E7 ^ 32'h20, 13, 1'b0, -1, 1'b1, 32'h19E7);
      bit_in(1'b1); bit_in(1'b0); start_pulse(); idle();
      expect_val("done_hold_crc", 32'h19E7); sb_check({19'b0, crc13});
      expect_val("done_hold_err", 32'h1);    sb_check(32'(err13));
      expect_val("done_hold_busy", 32'h0);   sb_check(32'(busy13));
      init_pulse();
      expect_val("init_err", 32'h0);         sb_check(32'(err13));
      expect_val("init_crc", 32'h0);         sb_check({19'b0, crc13});

      // Mismatch only on the final compared bit.
      init_pulse(); bit_in(1'b1);
      run_check("flip0", 32'h19E7 ^ 32'h1, 13, 1'b0, -1, 1'b1, 32'h19E7);

      // Accepted bit alongside check_start is dropped; stuffed bit in CHECK ignored.
      init_pulse(); bit_in(1'b1);
      run_check("startbit_stuff", 32'h19E7, 13, 1'b1, 6, 1'b0, 32'h19E7);

      // Empty frame from IDLE compares against the seed.
      init_pulse();
      run_check("empty", 32'h0, 13, 1'b0, -1, 1'b0, 32'h0);

      // rx_success after 6 compared bits aborts the check.
      init_pulse(); bit_in(1'b1); start_pulse();
      for (int i = 12; i >= 7; i--) bit_in(13'h19E7 >> i);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_val("abort_busy", 32'h0);       sb_check(32'(busy13));
      expect_val("abort_done", 32'h0);       sb_check(32'(done13));
      expect_val("abort_err", 32'h0);        sb_check(32'(err13));
      expect_val("abort_crc", 32'h0);        sb_check({19'b0, crc13});
      done_n = 0;
      busy_n = 0;
      for (int i = 6; i >= 0; i--) begin
         bit_in(13'h19E7 >> i);
         done_n += int'(done13); busy_n += int'(busy13);
      end
      expect_val("abort_no_done", 32'h0);    sb_check(32'(done_n));
      expect_val("abort_no_busy", 32'h0);    sb_check(32'(busy_n));

      // tx_success wins over check_start in the same cycle.
      init_pulse(); bit_in(1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_val("txs_prio_busy", 32'h0);    sb_check(32'(busy13));
      expect_val("txs_prio_crc", 32'h0);     sb_check({19'b0, crc13});

      // Asynchronous reset mid-ACCUM and mid-CHECK.
      init_pulse(); bit_in(1'b1); bit_in(1'b0);
      expect_val("accum_crc", 32'h0A29);     sb_check({19'b0, crc13});
      @(negedge clk); #2 g_rst_n = 1'b0; #1;
      expect_val("async_rst_crc", 32'h0);    sb_check({19'b0, crc13});
      expect_val("async_rst_err", 32'h0);    sb_check(32'(err13));
      @(negedge clk); g_rst_n = 1'b1;
      init_pulse(); bit_in(1'b1); start_pulse(); bit_in(1'b1);
      expect_val("pre_rst_busy", 32'h1);     sb_check(32'(busy13));
      @(negedge clk); #2 g_rst_n = 1'b0; #1;
      expect_val("async_rst_busy", 32'h0);   sb_check(32'(busy13));
      expect_val("async_rst_done", 32'h0);   sb_check(32'(done13));
      @(negedge clk); g_rst_n = 1'b1;

      // 32-bit instance seeded with all ones.
      use32 = 1'b1;
      init_pulse();
      expect_val("crc32_seed", 32'hFFFFFFFF); sb_check(crc32);
      expect_val("crc32_one_bit", 32'hFFFFFFFE ^ 32'h1EDC6F41);
      bit_in(1'b0);
      sb_check(crc32);
      run_check("crc32", 32'hFFFFFFFE ^ 32'h1EDC6F41, 32, 1'b0, -1, 1'b0,
                32'hFFFFFFFE ^ 32'h1EDC6F41);

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
